branch_resolve_queue: RTL

- In-order queue of in-flight predictions, directly downstream of the gshare predictor.
- On each prediction it captures the branch PC, the predicted direction and the GHR snapshot used to index the PHT.
- When the branch resolves, it pops the oldest entry and emits a registered update packet to the predictor's PHT/GHR training port.
- It also maintains saturating branch and misprediction counters used by the accuracy benches.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_sat_counter.sv | 25 ++
 rtl/branch_resolve_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default widths, the in-flight entry
// record and the PHT/GHR training packet used by the predictor and this queue.
package bp_pkg;

  localparam int BP_PC_W  = 8;
  localparam int BP_GHR_W = 8;

  typedef struct packed {
    logic [BP_PC_W-1:0]  pc;
    logic                pred;
    logic [BP_GHR_W-1:0] ghr;
  } bp_entry_t;

  localparam int BP_ENTRY_W = $bits(bp_entry_t);

  typedef struct packed {
    logic                valid;
    logic [BP_PC_W-1:0]  pc;
    logic [BP_GHR_W-1:0] ghr;
    logic                taken;
    logic                mispredict;
  } bp_upd_t;

  // Flat entry width for non-default widths; same {pc, pred, ghr} order as bp_entry_t.
  function automatic int entry_w(int pc_w, int ghr_w);
    return pc_w + 1 + ghr_w;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter: increments on inc and holds once it reaches all-ones.
module bp_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight gshare predictions; pops the oldest entry on
// resolve and emits a registered training packet plus accuracy counters.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH             = 8,
  parameter int PC_W              = BP_PC_W,
  parameter int GHR_W             = BP_GHR_W,
  parameter int CNT_W             = 16,
  parameter bit SQUASH_ON_MISPRED = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  logic [PC_W-1:0]          alloc_pc,
  input  logic                     alloc_pred,
  input  logic [GHR_W-1:0]         alloc_ghr,
  output logic                     alloc_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     resolve_ready,
  output logic                     upd_valid,
  output logic [PC_W-1:0]          upd_pc,
  output logic [GHR_W-1:0]         upd_ghr,
  output logic                     upd_taken,
  output logic                     upd_mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispredict_count
);

  // Handshakes: a transfer happens on a rising edge where valid & ready;
  // ready depends only on registered pointers, never on the same-cycle valid.

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(PC_W, GHR_W);

  logic [AW:0]          head_q, head_d, tail_q, tail_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   head_entry, alloc_entry;
  logic                 full, empty;
  logic                 alloc_fire, resolve_fire, mispred, squash;

  logic                 upd_valid_q, upd_valid_d;
  logic [PC_W-1:0]      upd_pc_q, upd_pc_d;
  logic [GHR_W-1:0]     upd_ghr_q, upd_ghr_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 upd_mis_q, upd_mis_d;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (head_q == tail_q);
  assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

  assign alloc_ready   = ~full;
  assign resolve_ready = ~empty;
  assign occupancy     = tail_q - head_q;

  assign head_entry   = mem_q[head_q[AW-1:0]];
  assign alloc_entry  = {alloc_pc, alloc_pred, alloc_ghr};
  assign resolve_fire = resolve_valid & resolve_ready;
  assign mispred      = head_entry[GHR_W] ^ resolve_taken;
  assign squash       = SQUASH_ON_MISPRED & resolve_fire & mispred;
  // A same-cycle alloc during a squash is wrong-path and is dropped.
  assign alloc_fire   = alloc_valid & alloc_ready & ~squash;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    upd_valid_d = resolve_fire;
    upd_pc_d    = upd_pc_q;
    upd_ghr_d   = upd_ghr_q;
    upd_taken_d = upd_taken_q;
    upd_mis_d   = upd_mis_q;
    if (resolve_fire) begin
      head_d      = head_q + 1'b1;
      upd_pc_d    = head_entry[ENTRY_W-1 -: PC_W];
      upd_ghr_d   = head_entry[GHR_W-1:0];
      upd_taken_d = resolve_taken;
      upd_mis_d   = mispred;
    end
    if (squash)          tail_d = head_q + 1'b1;
    else if (alloc_fire) tail_d = tail_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_ghr_q   <= '0;
      upd_taken_q <= 1'b0;
      upd_mis_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_ghr_q   <= upd_ghr_d;
      upd_taken_q <= upd_taken_d;
      upd_mis_q   <= upd_mis_d;
    end
  end

  // Entry storage is intentionally left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) mem_q[tail_q[AW-1:0]] <= alloc_entry;
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_ghr        = upd_ghr_q;
  assign upd_taken      = upd_taken_q;
  assign upd_mispredict = upd_mis_q;

  bp_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (resolve_fire),
    .count (branch_count)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (resolve_fire & mispred),
    .count (mispredict_count)
  );

endmodule
